// File: rtl/render_pkg.sv
// render_pkg
// Shared constants for the grid renderer: the default board geometry inside
// the 160x120 frame buffer, the 3-bit palette and the FSM state encoding.
// No ports; imported by the renderer top level.
package render_pkg;

  // Board geometry: an 8x8 board of CELL_PX-square cells whose top-left pixel
  // sits at (ORIGIN_X, ORIGIN_Y). Every board pixel is drawn once per frame.
  localparam int CELL_PX      = 12;
  localparam int ORIGIN_X     = 32;
  localparam int ORIGIN_Y     = 12;
  localparam int BOARD_PX     = 8 * CELL_PX;
  localparam int FRAME_PIXELS = BOARD_PX * BOARD_PX;

  // Palette
  localparam logic [2:0] COL_EMPTY  = 3'b000;
  localparam logic [2:0] COL_LINE   = 3'b111;
  localparam logic [2:0] COL_FILLED = 3'b001;
  localparam logic [2:0] COL_OVER   = 3'b100;
  localparam logic [2:0] COL_B1     = 3'b110;
  localparam logic [2:0] COL_B2     = 3'b011;
  localparam logic [2:0] COL_B3     = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/grid_renderer_if.sv
// grid_renderer_if
// Frame-control handshake plus the pixel write bus into the VGA frame buffer.
//   start      : request one frame draw (driven by the top level)
//   busy, done : frame in progress / one-cycle end-of-frame pulse
//   vga_x/y    : pixel coordinate, vga_colour : 3-bit colour
//   vga_plot   : write strobe for the frame buffer
// master = renderer side, slave = top level / frame buffer side.
interface grid_renderer_if;
  logic       start;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       done;

  modport master (
    input  start,
    output vga_x, vga_y, vga_colour, vga_plot, busy, done
  );

  modport slave (
    output start,
    input  vga_x, vga_y, vga_colour, vga_plot, busy, done
  );
endinterface

// File: rtl/block_cell_hit.sv
// block_cell_hit
// Combinational test of whether a block bitmap placed with its origin at
// cell (by, bx) covers board cell (r, c).
//   bitmap : 64-bit block shape, bit row*8+col
//   bx, by : block origin column / row
//   r, c   : board cell row / column being drawn
//   hit    : 1 when the block covers the cell
module block_cell_hit (
  input  logic [63:0] bitmap,
  input  logic [2:0]  bx,
  input  logic [2:0]  by,
  input  logic [2:0]  r,
  input  logic [2:0]  c,
  output logic        hit
);

  logic [2:0] dr;
  logic [2:0] dc;

  // Offsets into the block are only meaningful when the cell lies at or
  // below/right of the origin; the compare guards against the 3-bit
  // subtraction wrapping around to a bogus index.
  assign dr  = r - by;
  assign dc  = c - bx;
  assign hit = (r >= by) && (c >= bx) && bitmap[{dr, dc}];

endmodule

// File: rtl/grid_renderer.sv
// grid_renderer
// Draws the 8x8 game board into the 160x120 frame buffer, one pixel per clock,
// from a snapshot of the game state taken when the frame starts.
//   clk, reset         : clock, asynchronous active-low reset
//   bus (master)       : start/busy/done handshake and vga_x/y/colour/plot
//   game_grid          : board occupancy, bit r*8+c
//   game_over          : recolour occupied cells
//   block1..3          : block bitmaps, same indexing as game_grid
//   blockN_x, blockN_y : origin cell of each block
module grid_renderer #(
  parameter int         CELL_PX    = render_pkg::CELL_PX,
  parameter int         ORIGIN_X   = render_pkg::ORIGIN_X,
  parameter int         ORIGIN_Y   = render_pkg::ORIGIN_Y,
  parameter logic [2:0] COL_EMPTY  = render_pkg::COL_EMPTY,
  parameter logic [2:0] COL_LINE   = render_pkg::COL_LINE,
  parameter logic [2:0] COL_FILLED = render_pkg::COL_FILLED,
  parameter logic [2:0] COL_OVER   = render_pkg::COL_OVER,
  parameter logic [2:0] COL_B1     = render_pkg::COL_B1,
  parameter logic [2:0] COL_B2     = render_pkg::COL_B2,
  parameter logic [2:0] COL_B3     = render_pkg::COL_B3
) (
  input  logic        clk,
  input  logic        reset,
  grid_renderer_if.master bus,
  input  logic [63:0] game_grid,
  input  logic        game_over,
  input  logic [63:0] block1,
  input  logic [63:0] block2,
  input  logic [63:0] block3,
  input  logic [2:0]  block1_x,
  input  logic [2:0]  block1_y,
  input  logic [2:0]  block2_x,
  input  logic [2:0]  block2_y,
  input  logic [2:0]  block3_x,
  input  logic [2:0]  block3_y
);

  import render_pkg::*;

  state_t state;

  // Raster position: cell and sub-pixel within the cell, plus running screen
  // coordinates kept in step so no multiplier is needed.
  logic [2:0] cell_c;
  logic [2:0] cell_r;
  logic [3:0] sub_x;
  logic [3:0] sub_y;
  logic [7:0] cur_x;
  logic [6:0] cur_y;

  // Snapshot of the game state for the frame being drawn
  logic [63:0] snap_grid;
  logic        snap_over;
  logic [63:0] snap_b1;
  logic [63:0] snap_b2;
  logic [63:0] snap_b3;
  logic [2:0]  snap_b1x;
  logic [2:0]  snap_b1y;
  logic [2:0]  snap_b2x;
  logic [2:0]  snap_b2y;
  logic [2:0]  snap_b3x;
  logic [2:0]  snap_b3y;

  logic       hit1;
  logic       hit2;
  logic       hit3;
  logic [2:0] pix_colour;
  logic       sub_x_last;
  logic       sub_y_last;
  logic       frame_last;

  block_cell_hit u_hit1 (
    .bitmap (snap_b1), .bx (snap_b1x), .by (snap_b1y),
    .r (cell_r), .c (cell_c), .hit (hit1)
  );

  block_cell_hit u_hit2 (
    .bitmap (snap_b2), .bx (snap_b2x), .by (snap_b2y),
    .r (cell_r), .c (cell_c), .hit (hit2)
  );

  block_cell_hit u_hit3 (
    .bitmap (snap_b3), .bx (snap_b3x), .by (snap_b3y),
    .r (cell_r), .c (cell_c), .hit (hit3)
  );

  assign sub_x_last = (sub_x == 4'(CELL_PX - 1));
  assign sub_y_last = (sub_y == 4'(CELL_PX - 1));
  assign frame_last = sub_x_last && sub_y_last && (cell_c == 3'd7) && (cell_r == 3'd7);

  // Colour of the pixel under the current raster position. Grid lines sit on
  // sub-pixel row/column 0 of every cell and beat everything; block1 has the
  // highest overlay priority, then block2, block3, then the board itself.
  always_comb begin
    pix_colour = COL_EMPTY;
    if (sub_x == 4'd0 || sub_y == 4'd0) begin
      pix_colour = COL_LINE;
    end else if (hit1) begin
      pix_colour = COL_B1;
    end else if (hit2) begin
      pix_colour = COL_B2;
    end else if (hit3) begin
      pix_colour = COL_B3;
    end else if (snap_grid[{cell_r, cell_c}]) begin
      pix_colour = snap_over ? COL_OVER : COL_FILLED;
    end
  end

  // Frame FSM. IDLE waits for start and snapshots the game state; DRAW emits
  // one registered pixel per clock in row-major order across the whole board;
  // FIN drops the strobe and pulses done. Reset aborts a frame outright, so an
  // interrupted frame never reports done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cell_c         <= '0;
      cell_r         <= '0;
      sub_x          <= '0;
      sub_y          <= '0;
      cur_x          <= '0;
      cur_y          <= '0;
      snap_grid      <= '0;
      snap_over      <= 1'b0;
      snap_b1        <= '0;
      snap_b2        <= '0;
      snap_b3        <= '0;
      snap_b1x       <= '0;
      snap_b1y       <= '0;
      snap_b2x       <= '0;
      snap_b2y       <= '0;
      snap_b3x       <= '0;
      snap_b3y       <= '0;
      bus.vga_x      <= '0;
      bus.vga_y      <= '0;
      bus.vga_colour <= '0;
      bus.vga_plot   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done     <= 1'b0;
          bus.vga_plot <= 1'b0;
          if (bus.start) begin
            snap_grid <= game_grid;
            snap_over <= game_over;
            snap_b1   <= block1;
            snap_b2   <= block2;
            snap_b3   <= block3;
            snap_b1x  <= block1_x;
            snap_b1y  <= block1_y;
            snap_b2x  <= block2_x;
            snap_b2y  <= block2_y;
            snap_b3x  <= block3_x;
            snap_b3y  <= block3_y;
            cell_c    <= '0;
            cell_r    <= '0;
            sub_x     <= '0;
            sub_y     <= '0;
            cur_x     <= 8'(ORIGIN_X);
            cur_y     <= 7'(ORIGIN_Y);
            bus.busy  <= 1'b1;
            state     <= DRAW;
          end
        end

        DRAW: begin
          bus.vga_x      <= cur_x;
          bus.vga_y      <= cur_y;
          bus.vga_colour <= pix_colour;
          bus.vga_plot   <= 1'b1;
          if (!sub_x_last) begin
            sub_x <= sub_x + 4'd1;
            cur_x <= cur_x + 8'd1;
          end else begin
            sub_x <= '0;
            if (cell_c != 3'd7) begin
              cell_c <= cell_c + 3'd1;
              cur_x  <= cur_x + 8'd1;
            end else begin
              // End of a screen line: back to the left edge of the board
              cell_c <= '0;
              cur_x  <= 8'(ORIGIN_X);
              cur_y  <= cur_y + 7'd1;
              if (sub_y_last) begin
                sub_y  <= '0;
                cell_r <= cell_r + 3'd1;
              end else begin
                sub_y <= sub_y + 4'd1;
              end
            end
          end
          if (frame_last) begin
            state <= FIN;
          end
        end

        FIN: begin
          bus.vga_plot <= 1'b0;
          bus.done     <= 1'b1;
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
